// File: rtl/quiz_round_sequencer_pkg.sv
// Shared definitions for the quiz round sequencer.
// Contents:
//   - sizing constants: player slots, score width, index/time/count/points widths
//   - state_t: FSM encoding IDLE=0, OPEN=1, ANSWER=2, ROUND_END=3, OVER=4
//   - clamp helpers for player_count / question_count and the active-player mask
//   - saturating score add/subtract, evaluated one bit wider than a score
package comp_pkg;

  localparam int MAX_PLAYERS = 8;
  localparam int SCORE_W     = 7;
  localparam int IDX_W       = $clog2(MAX_PLAYERS);
  localparam int TIME_W      = 7;
  localparam int CNT_W       = 4;
  localparam int PTS_W       = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OPEN      = 3'd1,
    ANSWER    = 3'd2,
    ROUND_END = 3'd3,
    OVER      = 3'd4
  } state_t;

  // 0 players means a single player; anything above the slot count is capped.
  function automatic logic [CNT_W-1:0] clamp_player_count(input logic [CNT_W-1:0] pc);
    if (pc == '0) return CNT_W'(1);
    if (pc > CNT_W'(MAX_PLAYERS)) return CNT_W'(MAX_PLAYERS);
    return pc;
  endfunction

  // A game always has at least one question.
  function automatic logic [CNT_W-1:0] clamp_question_count(input logic [CNT_W-1:0] qc);
    if (qc == '0) return CNT_W'(1);
    return qc;
  endfunction

  // Bit i set when player slot i takes part in the game.
  function automatic logic [MAX_PLAYERS-1:0] active_mask(input logic [CNT_W-1:0] pc);
    logic [MAX_PLAYERS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      m[i] = (i < int'(pc));
    end
    return m;
  endfunction

  // Extra MSB of the sum flags overflow; clamp to the largest score.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                 input logic [PTS_W-1:0]   pts);
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {{(SCORE_W+1-PTS_W){1'b0}}, pts};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Extra MSB of the difference is the borrow; a borrow means the floor of 0.
  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] score,
                                                 input logic [PTS_W-1:0]   pts);
    logic [SCORE_W:0] diff;
    diff = {1'b0, score} - {{(SCORE_W+1-PTS_W){1'b0}}, pts};
    return diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/quiz_round_sequencer_if.sv
// Bus between the quiz round sequencer and its surroundings.
// master: input-edge layer / settings / display side (drives pulses and config,
//         reads status). slave: the sequencer itself.
// Signals:
//   tick_1hz, start, judge_ok, judge_fail : single-cycle pulses
//   buzz            : per-player buzz edge pulses
//   player_count, question_count, answer_time, win_score,
//   success_score, fail_score : game configuration
//   state, question_no, grant_valid, granted_player, time_left, lockout,
//   scores, game_over, winner_valid, winner : sequencer status
interface quiz_round_sequencer_if;
  import comp_pkg::*;

  logic                         tick_1hz;
  logic                         start;
  logic                         judge_ok;
  logic                         judge_fail;
  logic [MAX_PLAYERS-1:0]       buzz;
  logic [CNT_W-1:0]             player_count;
  logic [CNT_W-1:0]             question_count;
  logic [TIME_W-1:0]            answer_time;
  logic [SCORE_W-1:0]           win_score;
  logic [PTS_W-1:0]             success_score;
  logic [PTS_W-1:0]             fail_score;

  logic [2:0]                   state;
  logic [CNT_W-1:0]             question_no;
  logic                         grant_valid;
  logic [IDX_W-1:0]             granted_player;
  logic [TIME_W-1:0]            time_left;
  logic [MAX_PLAYERS-1:0]       lockout;
  logic [MAX_PLAYERS*SCORE_W-1:0] scores;
  logic                         game_over;
  logic                         winner_valid;
  logic [IDX_W-1:0]             winner;

  modport master (
    output tick_1hz, start, judge_ok, judge_fail, buzz,
           player_count, question_count, answer_time, win_score,
           success_score, fail_score,
    input  state, question_no, grant_valid, granted_player, time_left,
           lockout, scores, game_over, winner_valid, winner
  );

  modport slave (
    input  tick_1hz, start, judge_ok, judge_fail, buzz,
           player_count, question_count, answer_time, win_score,
           success_score, fail_score,
    output state, question_no, grant_valid, granted_player, time_left,
           lockout, scores, game_over, winner_valid, winner
  );

endinterface

// File: rtl/quiz_round_sequencer_arbiter.sv
// Combinational masked fixed-priority picker: lowest set bit of req & mask.
// Ports:
//   req   in  MAX_PLAYERS  request vector
//   mask  in  MAX_PLAYERS  qualifying mask
//   found out 1            some bit of req & mask is set
//   idx   out IDX_W        index of the lowest such bit (0 when none)
module buzz_priority_arbiter
  import comp_pkg::*;
(
  input  logic [MAX_PLAYERS-1:0] req,
  input  logic [MAX_PLAYERS-1:0] mask,
  output logic                   found,
  output logic [IDX_W-1:0]       idx
);

  logic [MAX_PLAYERS-1:0] eligible;

  assign eligible = req & mask;

  // Scan from the top down so the lowest eligible index is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/quiz_round_sequencer.sv
// Quiz round sequencer: runs one game of up to MAX_PLAYERS players.
// Per question: open buzz-in, grant the lowest-index eligible buzzer, count the
// answer time down on tick_1hz, apply the host judgement to the score, then
// decide whether the game is over and who won.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  quiz_round_sequencer_if.slave (pulses, configuration, status)
module quiz_round_sequencer
  import comp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  quiz_round_sequencer_if.slave  bus
);

  state_t                 state_reg;
  logic [CNT_W-1:0]       question_no_reg;
  logic                   grant_valid_reg;
  logic [IDX_W-1:0]       granted_player_reg;
  logic [TIME_W-1:0]      time_left_reg;
  logic [MAX_PLAYERS-1:0] lockout_reg;
  logic [SCORE_W-1:0]     score_reg [MAX_PLAYERS];
  logic                   game_over_reg;
  logic                   winner_valid_reg;
  logic [IDX_W-1:0]       winner_reg;

  // Configuration captured at the first start of the game.
  logic [CNT_W-1:0]       cfg_players_reg;
  logic [CNT_W-1:0]       cfg_questions_reg;
  logic [TIME_W-1:0]      cfg_answer_time_reg;
  logic [SCORE_W-1:0]     cfg_win_score_reg;
  logic [PTS_W-1:0]       cfg_success_reg;
  logic [PTS_W-1:0]       cfg_fail_reg;

  logic [MAX_PLAYERS-1:0] active;
  logic                   buzz_found;
  logic [IDX_W-1:0]       buzz_idx;
  logic [MAX_PLAYERS-1:0] meets_win;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [SCORE_W-1:0]     max_score;
  logic [IDX_W-1:0]       max_idx;
  logic                   max_tie;
  logic [SCORE_W-1:0]     granted_score;
  logic [MAX_PLAYERS-1:0] lockout_after_miss;
  logic                   judge_ok_only;
  logic                   judge_fail_only;
  logic                   timeout;

  assign active        = active_mask(cfg_players_reg);
  assign granted_score = score_reg[granted_player_reg];

  // Simultaneous ok+fail counts as no judgement, so a zero timer still expires.
  assign judge_ok_only   = bus.judge_ok & ~bus.judge_fail;
  assign judge_fail_only = bus.judge_fail & ~bus.judge_ok;
  assign timeout         = (time_left_reg == '0) & ~judge_ok_only & ~judge_fail_only;

  assign lockout_after_miss = lockout_reg | (MAX_PLAYERS'(1) << granted_player_reg);

  buzz_priority_arbiter u_buzz_arb (
    .req   (bus.buzz),
    .mask  (active & ~lockout_reg),
    .found (buzz_found),
    .idx   (buzz_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PLAYERS; gi++) begin : g_player
      assign meets_win[gi] = (score_reg[gi] >= cfg_win_score_reg);
      assign bus.scores[gi*SCORE_W +: SCORE_W] = score_reg[gi];
    end
  endgenerate

  // Same lowest-index picker, applied to the players at or above win_score.
  buzz_priority_arbiter u_win_arb (
    .req   (meets_win),
    .mask  (active),
    .found (win_found),
    .idx   (win_idx)
  );

  // Maximum active score; strict '>' keeps the lowest index among equals, and
  // max_tie flags a later player equalling the current maximum.
  always_comb begin
    max_score = score_reg[0];
    max_idx   = '0;
    max_tie   = 1'b0;
    for (int i = 1; i < MAX_PLAYERS; i++) begin
      if (active[i]) begin
        if (score_reg[i] > max_score) begin
          max_score = score_reg[i];
          max_idx   = IDX_W'(i);
          max_tie   = 1'b0;
        end else if (score_reg[i] == max_score) begin
          max_tie = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      question_no_reg     <= '0;
      grant_valid_reg     <= 1'b0;
      granted_player_reg  <= '0;
      time_left_reg       <= '0;
      lockout_reg         <= '0;
      game_over_reg       <= 1'b0;
      winner_valid_reg    <= 1'b0;
      winner_reg          <= '0;
      cfg_players_reg     <= '0;
      cfg_questions_reg   <= '0;
      cfg_answer_time_reg <= '0;
      cfg_win_score_reg   <= '0;
      cfg_success_reg     <= '0;
      cfg_fail_reg        <= '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        score_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (question_no_reg == '0) begin
              cfg_players_reg     <= clamp_player_count(bus.player_count);
              cfg_questions_reg   <= clamp_question_count(bus.question_count);
              cfg_answer_time_reg <= bus.answer_time;
              cfg_win_score_reg   <= bus.win_score;
              cfg_success_reg     <= bus.success_score;
              cfg_fail_reg        <= bus.fail_score;
            end
            question_no_reg <= question_no_reg + CNT_W'(1);
            lockout_reg     <= '0;
            state_reg       <= OPEN;
          end
        end

        OPEN: begin
          // An eligible buzz beats a simultaneous skip request.
          if (buzz_found) begin
            grant_valid_reg    <= 1'b1;
            granted_player_reg <= buzz_idx;
            time_left_reg      <= cfg_answer_time_reg;
            state_reg          <= ANSWER;
          end else if (bus.start) begin
            state_reg <= ROUND_END;
          end
        end

        ANSWER: begin
          if (judge_ok_only) begin
            score_reg[granted_player_reg] <= sat_add(granted_score, cfg_success_reg);
            grant_valid_reg               <= 1'b0;
            state_reg                     <= ROUND_END;
          end else if (judge_fail_only || timeout) begin
            score_reg[granted_player_reg] <= sat_sub(granted_score, cfg_fail_reg);
            lockout_reg                   <= lockout_after_miss;
            grant_valid_reg               <= 1'b0;
            state_reg <= ((active & ~lockout_after_miss) != '0) ? OPEN : ROUND_END;
          end else if (bus.tick_1hz && (time_left_reg != '0)) begin
            time_left_reg <= time_left_reg - TIME_W'(1);
          end
        end

        ROUND_END: begin
          if (win_found) begin
            game_over_reg    <= 1'b1;
            winner_valid_reg <= 1'b1;
            winner_reg       <= win_idx;
            state_reg        <= OVER;
          end else if (question_no_reg == cfg_questions_reg) begin
            game_over_reg    <= 1'b1;
            winner_valid_reg <= ~max_tie;
            winner_reg       <= max_idx;
            state_reg        <= OVER;
          end else begin
            state_reg <= IDLE;
          end
        end

        OVER: begin
          // Holds everything until reset.
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.state          = state_reg;
  assign bus.question_no    = question_no_reg;
  assign bus.grant_valid    = grant_valid_reg;
  assign bus.granted_player = granted_player_reg;
  assign bus.time_left      = time_left_reg;
  assign bus.lockout        = lockout_reg;
  assign bus.game_over      = game_over_reg;
  assign bus.winner_valid   = winner_valid_reg;
  assign bus.winner         = winner_reg;

endmodule

// File: tb/tb_quiz_round_sequencer.sv
module tb_quiz_round_sequencer;
  import comp_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  quiz_round_sequencer_if bus();

  quiz_round_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       jok;
    logic       jfail;
    logic       tick;
    logic [7:0] buzz;
    logic       cfg_change;
    logic [2:0] st;
    logic [3:0] qn;
    logic       gv;
    logic [2:0] gp;
    int         tl;     // -1: not checked
    logic [7:0] lock;
    int         sp;     // player whose score is checked, -1: none
    int         sv;
    logic       go;
    logic       wv;
    logic [2:0] win;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic s, logic jo, logic jf, logic tk, logic [7:0] bz,
                              logic cc, logic [2:0] st, logic [3:0] qn, logic gv,
                              logic [2:0] gp, int tl, logic [7:0] lk, int sp, int sv,
                              logic go, logic wv, logic [2:0] wn);
    vec_t v;
    v.start = s; v.jok = jo; v.jfail = jf; v.tick = tk; v.buzz = bz; v.cfg_change = cc;
    v.st = st; v.qn = qn; v.gv = gv; v.gp = gp; v.tl = tl; v.lock = lk;
    v.sp = sp; v.sv = sv; v.go = go; v.wv = wv; v.win = wn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int score_of(input int p);
    logic [SCORE_W-1:0] s;
    s = bus.scores[p*SCORE_W +: SCORE_W];
    return int'(s);
  endfunction

  task automatic clear_pulses();
    bus.start = 1'b0; bus.judge_ok = 1'b0; bus.judge_fail = 1'b0;
    bus.tick_1hz = 1'b0; bus.buzz = '0;
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, then pulses drop.
  task automatic cycle();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic set_cfg(input int pc, input int qc, input int at, input int ws,
                         input int ss, input int fs);
    bus.player_count = CNT_W'(pc); bus.question_count = CNT_W'(qc);
    bus.answer_time = TIME_W'(at); bus.win_score = SCORE_W'(ws);
    bus.success_score = PTS_W'(ss); bus.fail_score = PTS_W'(fs);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_qn"}, int'(bus.question_no), 0);
    check({tag, "_gv"}, int'(bus.grant_valid), 0);
    check({tag, "_gp"}, int'(bus.granted_player), 0);
    check({tag, "_tl"}, int'(bus.time_left), 0);
    check({tag, "_lock"}, int'(bus.lockout), 0);
    check({tag, "_scores"}, (bus.scores == '0) ? 1 : 0, 1);
    check({tag, "_go"}, int'(bus.game_over), 0);
    check({tag, "_wv"}, int'(bus.winner_valid), 0);
    check({tag, "_win"}, int'(bus.winner), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear_pulses();
    set_cfg(4, 2, 5, 10, 3, 1);

    // ---------------- reset state ----------------
    do_reset();
    check_reset("reset");
    $display("reset: state=%0d qn=%0d", bus.state, bus.question_no);

    // ---------------- table-driven main game ----------------
    //            st jo jf tk buzz   cc  st qn gv gp tl  lock   sp sv go wv win
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0,  1, 1, 0, 0,  0, 8'h00, -1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 8'h06, 0,  2, 1, 1, 1,  5, 8'h00, -1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 8'h00, 0,  1, 1, 0, 0, -1, 8'h02,  1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 8'h02, 0,  1, 1, 0, 0, -1, 8'h02, -1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 8'h04, 0,  2, 1, 1, 2,  5, 8'h02, -1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 8'h00, 0,  2, 1, 1, 2,  4, 8'h02, -1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 8'h00, 0,  2, 1, 1, 2,  3, 8'h02, -1, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 8'h00, 0,  2, 1, 1, 2,  2, 8'h02, -1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 8'h00, 0,  2, 1, 1, 2,  1, 8'h02, -1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 8'h00, 0,  2, 1, 1, 2,  0, 8'h02, -1, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 0,  1, 1, 0, 0, -1, 8'h06,  2, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 8'h10, 0,  1, 1, 0, 0, -1, 8'h06, -1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 8'h09, 0,  2, 1, 1, 0,  5, 8'h06, -1, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 8'h00, 0,  2, 1, 1, 0,  4, 8'h06,  0, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 8'h00, 0,  2, 1, 1, 0,  4, 8'h06, -1, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 8'h00, 0,  3, 1, 0, 0, -1, 8'h06,  0, 3, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 8'h00, 0,  0, 1, 0, 0, -1, 8'h06, -1, 0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 0, 8'h00, 1,  1, 2, 0, 0, -1, 8'h00, -1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 8'h02, 0,  2, 2, 1, 1,  5, 8'h00, -1, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 0, 0, 8'h00, 0,  3, 2, 0, 0, -1, 8'h00,  1, 3, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 8'h00, 0,  4, 2, 0, 0, -1, 8'h00, -1, 0, 1, 0, 0);
    vecs[21] = mk(1, 1, 0, 0, 8'h01, 0,  4, 2, 0, 0, -1, 8'h00,  0, 3, 1, 0, 0);

    for (int i = 0; i < 22; i++) begin
      // Changed settings mid-game must not be re-latched.
      if (vecs[i].cfg_change) set_cfg(1, 1, 9, 2, 7, 7);
      bus.start = vecs[i].start; bus.judge_ok = vecs[i].jok;
      bus.judge_fail = vecs[i].jfail; bus.tick_1hz = vecs[i].tick;
      bus.buzz = vecs[i].buzz;
      cycle();
      $display("vec %0d: state=%0d qn=%0d gv=%0d gp=%0d tl=%0d lock=%b go=%0d wv=%0d win=%0d",
               i, bus.state, bus.question_no, bus.grant_valid, bus.granted_player,
               bus.time_left, bus.lockout, bus.game_over, bus.winner_valid, bus.winner);
      check($sformatf("v%0d_state", i), int'(bus.state), int'(vecs[i].st));
      check($sformatf("v%0d_qn", i), int'(bus.question_no), int'(vecs[i].qn));
      check($sformatf("v%0d_gv", i), int'(bus.grant_valid), int'(vecs[i].gv));
      if (vecs[i].gv) check($sformatf("v%0d_gp", i), int'(bus.granted_player), int'(vecs[i].gp));
      if (vecs[i].tl >= 0) check($sformatf("v%0d_tl", i), int'(bus.time_left), vecs[i].tl);
      check($sformatf("v%0d_lock", i), int'(bus.lockout), int'(vecs[i].lock));
      if (vecs[i].sp >= 0) check($sformatf("v%0d_score", i), score_of(vecs[i].sp), vecs[i].sv);
      check($sformatf("v%0d_go", i), int'(bus.game_over), int'(vecs[i].go));
      check($sformatf("v%0d_wv", i), int'(bus.winner_valid), int'(vecs[i].wv));
      check($sformatf("v%0d_win", i), int'(bus.winner), int'(vecs[i].win));
    end

    // ---------------- win score with saturation at 127 ----------------
    set_cfg(3, 15, 3, 127, 15, 1);
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      bus.start = 1'b1;
      cycle();
      bus.buzz = 8'b0000_0110;
      cycle();
      check($sformatf("sat%0d_gp", k), int'(bus.granted_player), 1);
      bus.judge_ok = 1'b1;
      cycle();
      check($sformatf("sat%0d_score", k), score_of(1), (15 * k > 127) ? 127 : 15 * k);
      check($sformatf("sat%0d_re", k), int'(bus.state), 3);
      cycle();
      check($sformatf("sat%0d_next", k), int'(bus.state), (k < 9) ? 0 : 4);
      $display("sat round %0d: score1=%0d state=%0d", k, score_of(1), bus.state);
    end
    check("sat_go", int'(bus.game_over), 1);
    check("sat_wv", int'(bus.winner_valid), 1);
    check("sat_win", int'(bus.winner), 1);

    // ---------------- zero config values, instant timeout, last player out ----------------
    set_cfg(0, 0, 0, 10, 3, 1);
    do_reset();
    bus.start = 1'b1;
    cycle();
    check("z_open", int'(bus.state), 1);
    bus.buzz = 8'b0000_0010;          // player 1 is inactive with player_count 0
    cycle();
    check("z_inactive", int'(bus.grant_valid), 0);
    bus.buzz = 8'b0000_0001;
    cycle();
    check("z_grant", int'(bus.grant_valid), 1);
    check("z_tl", int'(bus.time_left), 0);
    cycle();
    check("z_timeout_state", int'(bus.state), 3);
    check("z_timeout_lock", int'(bus.lockout), 1);
    check("z_timeout_gv", int'(bus.grant_valid), 0);
    cycle();
    check("z_over", int'(bus.state), 4);
    check("z_go", int'(bus.game_over), 1);
    check("z_wv", int'(bus.winner_valid), 1);
    $display("zero cfg: state=%0d go=%0d wv=%0d", bus.state, bus.game_over, bus.winner_valid);

    // ---------------- reset during an answer ----------------
    set_cfg(4, 2, 5, 10, 3, 1);
    do_reset();
    bus.start = 1'b1;
    cycle();
    bus.buzz = 8'b0000_0010;
    cycle();
    bus.judge_fail = 1'b1;
    cycle();
    bus.buzz = 8'b0000_0100;
    cycle();
    bus.tick_1hz = 1'b1;
    cycle();
    bus.tick_1hz = 1'b1;
    cycle();
    check("mid_tl", int'(bus.time_left), 3);
    check("mid_gp", int'(bus.granted_player), 2);
    check("mid_lock", int'(bus.lockout), 2);
    rst = 1'b1;
    bus.judge_ok = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset("midrst");
    $display("mid-answer reset: state=%0d tl=%0d", bus.state, bus.time_left);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quiz_round_sequencer.md
Name: quiz_round_sequencer

Overview:
- Sequences one quiz game for up to 8 players.
- Per question it opens buzz-in, grants the first buzzer, runs the answer countdown, applies the host's judgement to the scores, and decides when the game ends and who won.
- Sits between the input-edge layer (buzz/host pulses) and the display views.
- Consumes the game configuration set up by the settings logic.

Parameters:
- MAX_PLAYERS, 8, number of player slots (buzz width, score array depth).
- SCORE_W, 7, width of each score register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-cycle pulse once per second
- start  in  1  host pulse: next question / skip current question
- judge_ok  in  1  host pulse: granted answer correct
- judge_fail  in  1  host pulse: granted answer wrong
- buzz  in  8  per-player buzz edge pulses
- player_count  in  4  active players; 0 is treated as 1, values above 8 as 8
- question_count  in  4  questions per game; 0 is treated as 1
- answer_time  in  7  seconds allowed per answer
- win_score  in  7  score that ends the game immediately
- success_score  in  4  points added on a correct answer
- fail_score  in  4  points removed on a wrong answer or timeout
- state  out  3  current FSM state
- question_no  out  4  current question number (1-based)
- grant_valid  out  1  a player currently holds the answer
- granted_player  out  3  index of the granted player
- time_left  out  7  remaining answer seconds
- lockout  out  8  players barred for the current question
- scores  out  8*SCORE_W  packed scores; player i at bits [i*SCORE_W +: SCORE_W]
- game_over  out  1  game finished
- winner_valid  out  1  a unique winner exists
- winner  out  3  winner index

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; question_no=0; all scores, lockout and time_left = 0.
  - grant_valid, game_over and winner_valid = 0; granted_player = 0; winner = 0.
  - rst takes effect in any state, including mid-answer.
- Configuration latch: all config inputs are captured when start is accepted with question_no==0. Later changes to them are ignored until rst.
- IDLE:
  - On start: question_no+=1, lockout cleared, go to OPEN.
  - judge_ok, judge_fail and buzz are ignored.
- OPEN:
  - Eligible buzz = buzz & active mask & ~lockout.
  - If any bit is eligible: the lowest index wins. Next cycle: grant_valid=1, granted_player=winner index, time_left=answer_time, state=ANSWER.
  - Buzzes from non-winning players in the same cycle are dropped.
  - start with no eligible buzz in the same cycle: question skipped, go to ROUND_END.
  - start and an eligible buzz in the same cycle: the buzz wins.
- ANSWER:
  - tick_1hz decrements time_left, saturating at 0.
  - A tick in the same cycle as the ANSWER entry is ignored.
  - judge_ok alone: score += success_score, saturating at 2^SCORE_W-1. grant_valid=0, go to ROUND_END.
  - judge_fail alone, or time_left==0 with no judge: score -= fail_score, floor 0. Set the player's lockout bit, grant_valid=0.
    - Go to OPEN if any active unlocked player remains, else ROUND_END.
  - judge_ok and judge_fail together: both ignored that cycle.
  - A judge pulse in the same cycle time_left reaches 0 wins over the timeout.
  - answer_time==0: timeout one cycle after entry.
  - buzz and start are ignored.
- ROUND_END (one cycle):
  - If any active score >= win_score: game_over=1, winner_valid=1, winner=lowest index among players meeting win_score. Go to OVER.
  - Else if question_no == latched question_count: game_over=1, winner=index of the maximum active score. winner_valid=0 on a tie for maximum (winner then holds the lowest tied index). Go to OVER.
  - Else go to IDLE.
- OVER: absorbing; all inputs ignored until rst. Outputs hold.
- Inactive players (index >= player_count): buzzes are ignored; scores stay 0 and are excluded from win/max checks.
- Score arithmetic is done at SCORE_W+1 bits, then clamped.

Decomposition:
- Shared package comp_pkg:
  - state encoding IDLE=0, OPEN=1, ANSWER=2, ROUND_END=3, OVER=4;
  - MAX_PLAYERS, SCORE_W;
  - clamp helper functions for player_count and question_count.
- Sub-module buzz_priority_arbiter:
  - combinational masked fixed-priority (lowest-index) pick;
  - outputs found and 3-bit index;
  - reused for the win-score scan.

Test Plan:
- rst, config 4 players/2 questions/answer_time 5/win 10/+3/-1. start; buzz=8'b0000_0110 in one cycle -> granted_player=1, time_left=5, state=ANSWER.
- In ANSWER with player 1 at score 0, judge_fail -> scores[1]=0 (floor), lockout=8'b0000_0010, state=OPEN. Then buzz from player 1 only -> no grant.
- Grant player 2, send 5 ticks without judging -> time_left 5..0, then timeout. Player 2 score 0 stays 0, lockout bit 2 set, state=OPEN.
- Player 0 scores 9, then a correct answer worth +3 -> score 12 >= 10. ROUND_END then OVER: game_over=1, winner_valid=1, winner=0.
- Two questions end with scores {3,3,0,0} -> game_over=1, winner_valid=0, winner=0. Changing the config inputs mid-game does not alter the question limit.
- Assert rst while in ANSWER with time_left=3 -> next cycle all outputs equal their reset values, state=IDLE.
